// File: rtl/npc_pkg.sv
// Shared types and constants for the trap controller and its neighbours.
package npc_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    JUMP = 2'd2,
    RET  = 2'd3
  } trap_state_e;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_BREAK   = 4'd3;
  localparam logic [3:0] EXC_ECALL_M = 4'd11;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

endpackage

// File: rtl/trap_redirect_reg.sv
// Valid/ready hold register for the PC redirect towards the IFU.
// Once loaded, valid and pc stay stable until the IFU accepts.
module trap_redirect_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o
);

  // Load a new target, or drop it once the handshake completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= load_pc_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer and CSR write-port arbiter.
// Optional mtval support is compiled in with the TRAP_MTVAL_EN macro.
//
// state | meaning
// IDLE  | accepting exceptions, mret and instruction CSR writes
// SAVE  | writing mepc/mcause (and mtval) for the captured exception
// JUMP  | redirecting to mtvec, waiting for IFU acceptance
// RET   | redirecting to mepc, waiting for IFU acceptance
module trap_ctrl import npc_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_code_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_valid_i,
  output logic            trap_ready_o,
  input  logic            insn_csr_wen_i,
  output logic            insn_csr_gnt_o,
  output logic            csr_wen_o,
  output logic            mepc_wen_o,
  output logic [XLEN-1:0] mepc_wdata_o,
  output logic            mcause_wen_o,
  output logic [XLEN-1:0] mcause_wdata_o,
  input  logic [XLEN-1:0] csr_mtvec_rdata_i,
  input  logic [XLEN-1:0] csr_mepc_rdata_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            busy_o
`ifdef TRAP_MTVAL_EN
  ,
  input  logic [XLEN-1:0] exc_tval_i,
  output logic            mtval_wen_o,
  output logic [XLEN-1:0] mtval_wdata_o
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [3:0]      code_q;
  logic            accept_exc;
  logic            redir_load;
  logic [XLEN-1:0] redir_pc_d;
  logic            redir_valid;
  logic            redir_done;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q;
`endif

  assign accept_exc = (state_q == IDLE) && exc_valid_i;
  assign redir_done = redir_valid && redirect_ready_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the faulting context when an exception is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= '0;
      code_q <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q <= '0;
`endif
    end else if (accept_exc) begin
      pc_q   <= exc_pc_i;
      code_q <= exc_code_i;
`ifdef TRAP_MTVAL_EN
      // ecall/ebreak carry no trap value.
      tval_q <= (exc_code_i == EXC_ECALL_M || exc_code_i == EXC_BREAK) ? '0 : exc_tval_i;
`endif
    end
  end

  // Next-state logic; exception wins over a simultaneous mret.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (exc_valid_i)       state_d = SAVE;
        else if (mret_valid_i) state_d = RET;
      end
      SAVE:     state_d = JUMP;
      JUMP,
      RET:  if (redir_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode: handshakes, CSR strobes and redirect load.
  always_comb begin
    trap_ready_o   = (state_q == IDLE);
    busy_o         = (state_q != IDLE);
    insn_csr_gnt_o = insn_csr_wen_i && (state_q == IDLE) && !exc_valid_i && !mret_valid_i;
    csr_wen_o      = insn_csr_gnt_o;
    mepc_wen_o     = 1'b0;
    mepc_wdata_o   = '0;
    mcause_wen_o   = 1'b0;
    mcause_wdata_o = '0;
`ifdef TRAP_MTVAL_EN
    mtval_wen_o    = 1'b0;
    mtval_wdata_o  = '0;
`endif
    redir_load     = 1'b0;
    redir_pc_d     = csr_mepc_rdata_i & ALIGN_MASK;
    if (state_q == SAVE) begin
      mepc_wen_o     = 1'b1;
      mepc_wdata_o   = pc_q & ALIGN_MASK;
      mcause_wen_o   = 1'b1;
      mcause_wdata_o = {{(XLEN-4){1'b0}}, code_q};
`ifdef TRAP_MTVAL_EN
      mtval_wen_o    = 1'b1;
      mtval_wdata_o  = tval_q;
`endif
      redir_load     = 1'b1;
      redir_pc_d     = csr_mtvec_rdata_i & ALIGN_MASK;
    end else if (state_q == IDLE && !exc_valid_i && mret_valid_i) begin
      redir_load     = 1'b1;
    end
  end

  trap_redirect_reg #(.XLEN(XLEN)) u_redirect (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (redir_load),
    .load_pc_i (redir_pc_d),
    .ready_i   (redirect_ready_i),
    .valid_o   (redir_valid),
    .pc_o      (redirect_pc_o)
  );

  assign redirect_valid_o = redir_valid;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized transaction-level bench for trap_ctrl. Each transaction is
// expanded into a per-cycle expected timeline from its parameters.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exc_valid_i;
  logic [3:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        mret_valid_i;
  logic        trap_ready_o;
  logic        insn_csr_wen_i;
  logic        insn_csr_gnt_o;
  logic        csr_wen_o;
  logic        mepc_wen_o;
  logic [31:0] mepc_wdata_o;
  logic        mcause_wen_o;
  logic [31:0] mcause_wdata_o;
  logic [31:0] csr_mtvec_rdata_i;
  logic [31:0] csr_mepc_rdata_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        busy_o;
`ifdef TRAP_MTVAL_EN
  logic [31:0] exc_tval_i;
  logic        mtval_wen_o;
  logic [31:0] mtval_wdata_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.XLEN(32)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .exc_valid_i       (exc_valid_i),
    .exc_code_i        (exc_code_i),
    .exc_pc_i          (exc_pc_i),
    .mret_valid_i      (mret_valid_i),
    .trap_ready_o      (trap_ready_o),
    .insn_csr_wen_i    (insn_csr_wen_i),
    .insn_csr_gnt_o    (insn_csr_gnt_o),
    .csr_wen_o         (csr_wen_o),
    .mepc_wen_o        (mepc_wen_o),
    .mepc_wdata_o      (mepc_wdata_o),
    .mcause_wen_o      (mcause_wen_o),
    .mcause_wdata_o    (mcause_wdata_o),
    .csr_mtvec_rdata_i (csr_mtvec_rdata_i),
    .csr_mepc_rdata_i  (csr_mepc_rdata_i),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .redirect_ready_i  (redirect_ready_i),
    .busy_o            (busy_o)
`ifdef TRAP_MTVAL_EN
    ,
    .exc_tval_i        (exc_tval_i),
    .mtval_wen_o       (mtval_wen_o),
    .mtval_wdata_o     (mtval_wdata_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    exc_valid_i      = 1'b0;
    mret_valid_i     = 1'b0;
    insn_csr_wen_i   = 1'b0;
    redirect_ready_i = 1'b0;
  endtask

  // Compare every output against the expected picture of this cycle.
  task automatic expect_outs(input string ph, input logic e_rdy, input logic e_busy,
                             input logic e_rv, input logic [31:0] e_rpc,
                             input logic e_sw, input logic [31:0] e_mepc,
                             input logic [31:0] e_mcause, input logic [31:0] e_mtval,
                             input logic e_gnt);
    @(negedge clk_i);
    check({ph, ".trap_ready"}, 32'(trap_ready_o), 32'(e_rdy));
    check({ph, ".busy"}, 32'(busy_o), 32'(e_busy));
    check({ph, ".redirect_valid"}, 32'(redirect_valid_o), 32'(e_rv));
    if (e_rv) check({ph, ".redirect_pc"}, redirect_pc_o, e_rpc);
    check({ph, ".mepc_wen"}, 32'(mepc_wen_o), 32'(e_sw));
    check({ph, ".mcause_wen"}, 32'(mcause_wen_o), 32'(e_sw));
    if (e_sw) begin
      check({ph, ".mepc_wdata"}, mepc_wdata_o, e_mepc);
      check({ph, ".mcause_wdata"}, mcause_wdata_o, e_mcause);
    end
`ifdef TRAP_MTVAL_EN
    check({ph, ".mtval_wen"}, 32'(mtval_wen_o), 32'(e_sw));
    if (e_sw) check({ph, ".mtval_wdata"}, mtval_wdata_o, e_mtval);
`else
    if (e_sw && e_mtval === 32'hx) $display("note: no mtval in this build");
`endif
    check({ph, ".insn_csr_gnt"}, 32'(insn_csr_gnt_o), 32'(e_gnt));
    check({ph, ".csr_wen"}, 32'(csr_wen_o), 32'(e_gnt));
  endtask

  // First IDLE cycle with no trap request: a held CSR write is granted.
  task automatic idle_check(input string ph, input logic req);
    next_cycle();
    quiet_inputs();
    redirect_ready_i = 1'($urandom_range(0, 1));
    insn_csr_wen_i   = req;
    expect_outs({ph, ".idle"}, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, req);
  endtask

  // Wait k cycles of backpressure, then the IFU accepts.
  task automatic redirect_phase(input string ph, input logic [31:0] tgt, input int k,
                                input logic req);
    for (int i = 0; i <= k; i++) begin
      next_cycle();
      redirect_ready_i = (i == k);
      exc_valid_i      = (i < k) ? 1'($urandom_range(0, 1)) : 1'b0;
      mret_valid_i     = (i < k) ? 1'($urandom_range(0, 1)) : 1'b0;
      insn_csr_wen_i   = req;
      expect_outs(ph, 1'b0, 1'b1, 1'b1, tgt & 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic do_exc(input logic [3:0] c, input logic [31:0] p, input logic [31:0] tv,
                        input logic [31:0] mt, input logic [31:0] me, input int k,
                        input logic both, input logic req);
    logic [31:0] e_tval;
    e_tval = (c == 4'd3 || c == 4'd11) ? 32'h0 : tv;
    next_cycle();
    quiet_inputs();
    exc_valid_i       = 1'b1;
    exc_code_i        = c;
    exc_pc_i          = p;
`ifdef TRAP_MTVAL_EN
    exc_tval_i        = tv;
`endif
    mret_valid_i      = both;
    insn_csr_wen_i    = req;
    csr_mtvec_rdata_i = mt;
    csr_mepc_rdata_i  = me;
    redirect_ready_i  = 1'($urandom_range(0, 1));
    expect_outs("exc.accept", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    next_cycle();
    exc_valid_i      = 1'b0;
    mret_valid_i     = 1'b0;
    exc_pc_i         = $urandom;
`ifdef TRAP_MTVAL_EN
    exc_tval_i       = $urandom;
`endif
    redirect_ready_i = 1'($urandom_range(0, 1));
    expect_outs("exc.save", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, p & 32'hFFFF_FFFC, {28'h0, c},
                e_tval, 1'b0);
    redirect_phase("exc.jump", mt, k, req);
    idle_check("exc", req);
  endtask

  task automatic do_mret(input logic [31:0] me, input logic [31:0] mt, input int k,
                         input logic req);
    next_cycle();
    quiet_inputs();
    mret_valid_i      = 1'b1;
    insn_csr_wen_i    = req;
    csr_mepc_rdata_i  = me;
    csr_mtvec_rdata_i = mt;
    redirect_ready_i  = 1'($urandom_range(0, 1));
    expect_outs("mret.accept", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    redirect_phase("mret.ret", me, k, req);
    idle_check("mret", req);
  endtask

  // Reset taken mid-sequence: 0 = in SAVE, 1 = in JUMP, 2 = in RET.
  task automatic do_reset(input int where);
    next_cycle();
    quiet_inputs();
    csr_mtvec_rdata_i = $urandom;
    csr_mepc_rdata_i  = $urandom;
    exc_pc_i          = $urandom;
    exc_code_i        = 4'd2;
    if (where == 2) mret_valid_i = 1'b1;
    else            exc_valid_i  = 1'b1;
    if (where == 1) begin
      next_cycle();
      quiet_inputs();
    end
    next_cycle();
    quiet_inputs();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst.trap_ready", 32'(trap_ready_o), 32'd1);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.redirect_valid", 32'(redirect_valid_o), 32'd0);
    check("rst.redirect_pc", redirect_pc_o, 32'd0);
    check("rst.mepc_wen", 32'(mepc_wen_o), 32'd0);
    check("rst.mepc_wdata", mepc_wdata_o, 32'd0);
    check("rst.mcause_wen", 32'(mcause_wen_o), 32'd0);
    check("rst.mcause_wdata", mcause_wdata_o, 32'd0);
    check("rst.gnt", 32'(insn_csr_gnt_o), 32'd0);
`ifdef TRAP_MTVAL_EN
    check("rst.mtval_wen", 32'(mtval_wen_o), 32'd0);
`endif
    // The first cycle after reset must not produce a redirect either.
    expect_outs("rst.after", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [3:0] codes [3];
    codes[0] = 4'd2;
    codes[1] = 4'd3;
    codes[2] = 4'd11;
    quiet_inputs();
    rst_i             = 1'b1;
    exc_code_i        = 4'd0;
    exc_pc_i          = 32'h0;
    csr_mtvec_rdata_i = 32'h0;
    csr_mepc_rdata_i  = 32'h0;
`ifdef TRAP_MTVAL_EN
    exc_tval_i        = 32'h0;
`endif
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
    expect_outs("init", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("init.redirect_pc", redirect_pc_o, 32'h0);

    do_exc(4'd11, 32'h8000_0010, 32'h1234_5678, 32'h8000_1003, 32'h0, 0, 1'b0, 1'b0);
    do_mret(32'h8000_0014, 32'h8000_1003, 3, 1'b0);
    do_exc(4'd3, 32'h8000_0022, 32'h5555_0000, 32'h8000_2001, 32'h9000_0000, 1, 1'b1, 1'b0);
    do_exc(4'd2, 32'h8000_0100, 32'hDEAD_BEEF, 32'h8000_3000, 32'h9000_0004, 2, 1'b0, 1'b1);
    do_reset(1);

    for (int t = 0; t < 80; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 4)
        do_exc(codes[$urandom_range(0, 2)], $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      else if (kind <= 7)
        do_mret($urandom, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else if (kind == 8)
        idle_check("csr", 1'($urandom_range(0, 1)));
      else
        do_reset($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences RISC-V machine-mode trap entry (ecall/ebreak/illegal-instruction exceptions) and trap return (mret) against the CSR unit.
- Captures the faulting PC and cause, writes mepc/mcause, reads mtvec/mepc and issues a PC redirect to IFU over a valid/ready handshake.
- Also arbitrates the CSR write port between CSRRW/CSRRS/CSRRC instructions and trap writes.
- Sits between EXU/WBU and the CSR unit.

Parameters:
- XLEN, 32, datapath and CSR width.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- exc_valid_i  input  1  exception request from EXU
- exc_code_i  input  4  exception code (2 illegal, 3 ebreak, 11 ecall-M)
- exc_pc_i  input  XLEN  PC of faulting instruction
- mret_valid_i  input  1  mret request from EXU
- trap_ready_o  output  1  exception/mret accepted this cycle (high only in IDLE)
- insn_csr_wen_i  input  1  instruction CSR write request
- insn_csr_gnt_o  output  1  instruction CSR write granted
- csr_wen_o  output  1  forwarded instruction CSR write enable
- mepc_wen_o  output  1  mepc write strobe
- mepc_wdata_o  output  XLEN  mepc write data
- mcause_wen_o  output  1  mcause write strobe
- mcause_wdata_o  output  XLEN  mcause write data
- csr_mtvec_rdata_i  input  XLEN  current mtvec
- csr_mepc_rdata_i  input  XLEN  current mepc
- redirect_valid_o  output  1  PC redirect valid
- redirect_pc_o  output  XLEN  redirect target
- redirect_ready_i  input  1  IFU accepts redirect
- busy_o  output  1  trap sequence in progress; pipeline stalls

Behaviour:
- Clock is clk_i. Reset is rst_i, synchronous and active-high.
- Reset values:
  - FSM=IDLE.
  - All outputs 0.
  - Captured PC and code registers 0.
- FSM states: IDLE, SAVE, JUMP, RET.
- IDLE:
  - trap_ready_o=1 and busy_o=0.
  - exc_valid_i=1: latch exc_pc_i and exc_code_i, then go to SAVE.
  - Otherwise mret_valid_i=1: go to RET.
  - Exception has priority over mret when both are high; the mret is dropped and EXU must not re-present it (it is flushed).
- SAVE (exactly 1 cycle):
  - mepc_wen_o=1, mepc_wdata_o = latched PC with bits[1:0] cleared.
  - mcause_wen_o=1, mcause_wdata_o = zero-extended code (bit XLEN-1 = 0).
  - Next state JUMP.
- JUMP:
  - redirect_valid_o=1, redirect_pc_o = csr_mtvec_rdata_i with bits[1:0] cleared (direct mode only).
  - Hold valid and pc stable until redirect_ready_i=1, then go to IDLE.
- RET:
  - redirect_valid_o=1, redirect_pc_o = csr_mepc_rdata_i with bits[1:0] cleared.
  - Hold until redirect_ready_i=1, then go to IDLE.
- Latency:
  - Exception accepted in cycle N: mepc/mcause writes in N+1, redirect_valid first in N+2.
  - mret accepted in N: redirect_valid in N+1.
  - Either may be extended by redirect_ready_i backpressure.
- busy_o = (state != IDLE).
- CSR arbitration:
  - insn_csr_gnt_o = insn_csr_wen_i & IDLE & ~exc_valid_i & ~mret_valid_i.
  - csr_wen_o = insn_csr_gnt_o.
  - An ungranted request must be held by EXU.
  - Trap writes and instruction writes never occur in the same cycle.
- Requests arriving in non-IDLE states are ignored (trap_ready_o=0). The requester holds them.
- redirect_ready_i high outside JUMP/RET has no effect.
- Reset asserted in any state returns to IDLE next edge with no pending write or redirect.

Optional Feature:
- Macro: TRAP_MTVAL_EN.
- When defined:
  - Adds ports exc_tval_i (input, XLEN), mtval_wen_o (output, 1) and mtval_wdata_o (output, XLEN).
  - tval is latched with the exception and written in SAVE alongside mepc/mcause.
  - For ecall/ebreak, mtval_wdata_o is 0 regardless of exc_tval_i.
- When undefined: none of these ports exist and no mtval write occurs.

Decomposition:
- Shared package (npc_pkg):
  - XLEN.
  - trap_state_e enum (IDLE, SAVE, JUMP, RET).
  - Exception code constants EXC_ILLEGAL=2, EXC_BREAK=3, EXC_ECALL_M=11.
  - CSR address constants CSR_MTVEC=12'h305, CSR_MEPC=12'h341, CSR_MCAUSE=12'h342, CSR_MTVAL=12'h343.
- One sub-module is natural: trap_redirect_reg, a valid/ready hold register for redirect_pc_o.

Test Plan:
- ecall at PC 0x8000_0010, mtvec=0x8000_1003, ready=1:
  - N+1: mepc_wdata=0x8000_0010, mcause_wdata=11.
  - N+2: redirect_pc=0x8000_1000; IDLE at N+3.
- mret with mepc=0x8000_0014, redirect_ready held low 3 cycles:
  - redirect_valid stays high with pc 0x8000_0014 for 4 cycles.
  - busy_o drops the cycle after the handshake.
- exc_valid_i and mret_valid_i high together (code 3):
  - Exception taken, mcause=3, no RET visit.
- insn_csr_wen_i high during SAVE/JUMP:
  - insn_csr_gnt_o=0 throughout.
  - Grant in first IDLE cycle with no trap request.
- Reset asserted in JUMP with redirect_ready_i=0:
  - Next cycle all outputs 0, state IDLE, trap_ready_o=1.
- TRAP_MTVAL_EN: illegal instruction with tval=0xDEAD_BEEF:
  - mtval_wen_o=1, mtval_wdata_o=0xDEAD_BEEF in SAVE.
  - For ecall, mtval_wdata_o=0.
